// File: rtl/led_matrix_scanner.sv
// Multiplexed LED-matrix scanner: double-buffered 1bpp frame store,
// serial column shift-out, per-plane PWM on-window, self-timed scan.
module led_matrix_scanner #(
  parameter int ROWS    = 8,
  parameter int COLS    = 8,
  parameter int COLORS  = 2,
  parameter int BB      = 2,
  parameter int CLK_DIV = 1350,
  localparam int CW = (COLORS > 1) ? $clog2(COLORS) : 1,
  localparam int RW = $clog2(ROWS),
  localparam int LW = $clog2(COLS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_en,
  input  logic [CW-1:0]        wr_color,
  input  logic [RW-1:0]        wr_row,
  input  logic [LW-1:0]        wr_col,
  input  logic                 wr_data,
  input  logic                 swap_req,
  output logic                 swap_ack,
  input  logic [COLORS*BB-1:0] bright,
  output logic                 ser_data,
  output logic                 ser_clk,
  output logic                 ser_latch,
  output logic [ROWS-1:0]      row_en_n,
  output logic [COLORS-1:0]    col_en_n,
  output logic                 frame_start
);

  localparam int DW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [LW-1:0] COL_LAST = LW'(COLS - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(ROWS - 1);
  localparam logic [CW-1:0] PLN_LAST = CW'(COLORS - 1);
  localparam logic [BB-1:0] ON_LAST  = BB'((1 << BB) - 1);

  typedef enum logic [1:0] {
    SHIFT_LO,
    SHIFT_HI,
    LATCH,
    ON
  } state_t;

  state_t        state;
  logic [DW-1:0] div;
  logic          tick;
  logic [RW-1:0] row;
  logic [CW-1:0] plane;
  logic [LW-1:0] col;
  logic [BB-1:0] on_cnt;
  logic [BB-1:0] bcap;
  logic          bank;
  logic          pend;
  logic          boundary;
  logic          do_swap;
  logic          rbank;
  logic          wr_ok;

  logic [COLS-1:0] fb [2][COLORS][ROWS];

  assign tick = (div == DW'(CLK_DIV - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div <= '0;
    end else if (tick) begin
      div <= '0;
    end else begin
      div <= div + 1'b1;
    end
  end

  assign wr_ok = wr_en
              && (int'(wr_color) < COLORS)
              && (int'(wr_row) < ROWS)
              && (int'(wr_col) < COLS);

  // Storage has no reset so a panel reset keeps the picture.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      fb[~bank][wr_color][wr_row][wr_col] <= wr_data;
    end
  end

  assign boundary = (state == SHIFT_LO)
                 && (row == '0)
                 && (plane == '0)
                 && (col == COL_LAST);
  assign do_swap = tick && boundary && (pend || swap_req);
  // The first column of a swapped frame already comes from the new front.
  assign rbank = bank ^ do_swap;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= SHIFT_LO;
      row         <= '0;
      plane       <= '0;
      col         <= COL_LAST;
      on_cnt      <= '0;
      bcap        <= '0;
      bank        <= 1'b0;
      pend        <= 1'b0;
      ser_data    <= 1'b0;
      ser_clk     <= 1'b0;
      ser_latch   <= 1'b0;
      swap_ack    <= 1'b0;
      frame_start <= 1'b0;
      row_en_n    <= '1;
      col_en_n    <= '1;
    end else begin
      frame_start <= 1'b0;
      swap_ack    <= 1'b0;
      if (do_swap) begin
        pend <= 1'b0;
      end else if (swap_req) begin
        pend <= 1'b1;
      end
      if (tick) begin
        unique case (state)
          SHIFT_LO: begin
            ser_clk   <= 1'b0;
            ser_latch <= 1'b0;
            ser_data  <= fb[rbank][plane][row][col];
            row_en_n  <= '1;
            col_en_n  <= '1;
            state     <= SHIFT_HI;
            if (boundary) begin
              frame_start <= 1'b1;
            end
            if (do_swap) begin
              bank     <= ~bank;
              swap_ack <= 1'b1;
            end
          end
          SHIFT_HI: begin
            ser_clk <= 1'b1;
            if (col == '0) begin
              col   <= COL_LAST;
              state <= LATCH;
            end else begin
              col   <= col - 1'b1;
              state <= SHIFT_LO;
            end
          end
          LATCH: begin
            ser_clk   <= 1'b0;
            ser_latch <= 1'b1;
            bcap      <= bright[plane*BB +: BB];
            on_cnt    <= '0;
            state     <= ON;
          end
          ON: begin
            ser_latch <= 1'b0;
            if (on_cnt < bcap) begin
              row_en_n <= ~(ROWS'(1) << row);
              col_en_n <= ~(COLORS'(1) << plane);
            end else begin
              row_en_n <= '1;
              col_en_n <= '1;
            end
            on_cnt <= on_cnt + 1'b1;
            if (on_cnt == ON_LAST) begin
              state <= SHIFT_LO;
              if (plane == PLN_LAST) begin
                plane <= '0;
                if (row == ROW_LAST) begin
                  row <= '0;
                end else begin
                  row <= row + 1'b1;
                end
              end else begin
                plane <= plane + 1'b1;
              end
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_led_matrix_scanner.sv
// Scoreboard bench for led_matrix_scanner: stimulus queues expected
// slot words and on-times, a negedge monitor pops and compares them.
module tb_led_matrix_scanner;

  localparam int ROWS    = 6;
  localparam int COLS    = 8;
  localparam int COLORS  = 2;
  localparam int BB      = 2;
  localparam int CLK_DIV = 4;
  localparam int SLOT    = 2 * COLS + 1 + (1 << BB);
  localparam int FR_CLK  = ROWS * COLORS * SLOT * CLK_DIV;
  localparam int ON_CLK  = (1 << BB) * CLK_DIV;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 wr_en;
  logic [0:0]           wr_color;
  logic [2:0]           wr_row;
  logic [2:0]           wr_col;
  logic                 wr_data;
  logic                 swap_req;
  logic                 swap_ack;
  logic [COLORS*BB-1:0] bright;
  logic                 ser_data;
  logic                 ser_clk;
  logic                 ser_latch;
  logic [ROWS-1:0]      row_en_n;
  logic [COLORS-1:0]    col_en_n;
  logic                 frame_start;

  led_matrix_scanner #(
    .ROWS(ROWS), .COLS(COLS), .COLORS(COLORS),
    .BB(BB), .CLK_DIV(CLK_DIV)
  ) dut (
    .clk(clk), .rst(rst),
    .wr_en(wr_en), .wr_color(wr_color),
    .wr_row(wr_row), .wr_col(wr_col),
    .wr_data(wr_data),
    .swap_req(swap_req), .swap_ack(swap_ack),
    .bright(bright),
    .ser_data(ser_data), .ser_clk(ser_clk),
    .ser_latch(ser_latch),
    .row_en_n(row_en_n), .col_en_n(col_en_n),
    .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  typedef struct {
    int row;
    int plane;
    int w;
  } wexp_t;

  typedef struct {
    int row;
    int plane;
    int cnt;
  } oexp_t;

  wexp_t q_w[$];
  oexp_t q_on[$];

  int applied = 0;
  int errs = 0;
  int acks = 0;
  int exp_acks = 0;
  int mb = 0;
  logic [COLS-1:0] mdl [2][COLORS][ROWS];

  task automatic chk(input string name, input int act, input int exp);
    applied++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d at %0t",
               name, act, exp, $time);
    end
  endtask

  task automatic push_words();
    for (int r = 0; r < ROWS; r++)
      for (int p = 0; p < COLORS; p++)
        q_w.push_back(wexp_t'{r, p, int'(mdl[mb][p][r])});
  endtask

  task automatic push_on();
    for (int r = 0; r < ROWS; r++)
      for (int p = 0; p < COLORS; p++)
        q_on.push_back(oexp_t'{r, p,
          int'(bright[p*BB +: BB]) * CLK_DIV});
  endtask

  task automatic wr(input int c, input int r,
                    input int cl, input logic d);
    wr_en    = 1'b1;
    wr_color = 1'(c);
    wr_row   = 3'(r);
    wr_col   = 3'(cl);
    wr_data  = d;
    mdl[mb ^ 1][c][r][cl] = d;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic clear_back();
    for (int c = 0; c < COLORS; c++)
      for (int r = 0; r < ROWS; r++)
        for (int k = 0; k < COLS; k++)
          wr(c, r, k, 1'b0);
  endtask

  task automatic wait_fs();
    int  k = 0;
    bit  seen = 1'b0;
    while (!seen && k < 2 * FR_CLK) begin
      @(negedge clk);
      k++;
      seen = frame_start;
    end
    chk("fs_seen", int'(seen), 1);
  endtask

  task automatic swap_and_wait();
    swap_req = 1'b1;
    @(negedge clk);
    swap_req = 1'b0;
    wait_fs();
    mb ^= 1;
    exp_acks++;
  endtask

  task automatic after_rst();
    int  k = 0;
    bit  seen = 1'b0;
    while (!seen && k < 4 * CLK_DIV) begin
      @(negedge clk);
      k++;
      seen = frame_start;
    end
    chk("fs_first_tick", k, CLK_DIV);
    chk("no_ack_first", int'(swap_ack), 0);
  endtask

  // Monitor: decodes the serial stream and enable windows.
  initial begin
    int cyc = 0;
    int last_fs = -1;
    int last_rise = -1;
    int lat_len = 0;
    int sidx = 0;
    int cur_r = 0;
    int cur_p = 0;
    int nbits = 0;
    int win_left = 0;
    int wcnt = 0;
    int stray = 0;
    logic prev_sclk = 1'b0;
    logic prev_lat = 1'b0;
    logic [COLS-1:0] acc = '0;
    logic [ROWS-1:0] er;
    logic [COLORS-1:0] ec;
    wexp_t we;
    oexp_t oe;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        last_fs = -1;
        last_rise = -1;
        lat_len = 0;
        sidx = 0;
        nbits = 0;
        acc = '0;
        win_left = 0;
        prev_sclk = 1'b0;
        prev_lat = 1'b0;
      end else begin
        if (frame_start) begin
          if (last_fs >= 0)
            chk("fs_period", cyc - last_fs, FR_CLK);
          last_fs = cyc;
          sidx = 0;
        end
        if (swap_ack) begin
          acks++;
          chk("ack_with_fs", int'(frame_start), 1);
        end
        if (ser_clk && !prev_sclk) begin
          if (last_rise >= 0)
            chk("sclk_period", cyc - last_rise, 2 * CLK_DIV);
          last_rise = cyc;
          acc = {acc[COLS-2:0], ser_data};
          nbits++;
        end
        if (ser_latch) lat_len++;
        if (ser_latch && !prev_lat) begin
          cur_r = sidx / COLORS;
          cur_p = sidx % COLORS;
          if (q_w.size() > 0) begin
            we = q_w.pop_front();
            chk("slot_pos", sidx, we.row * COLORS + we.plane);
            chk("slot_word", int'(acc), we.w);
            chk("slot_bits", nbits, COLS);
            chk("blank_latch",
                int'((&row_en_n) && (&col_en_n)), 1);
          end
          sidx++;
          acc = '0;
          nbits = 0;
          last_rise = -1;
        end
        if (!ser_latch && prev_lat) begin
          chk("latch_len", lat_len, CLK_DIV);
          lat_len = 0;
          win_left = ON_CLK;
          wcnt = 0;
          stray = 0;
        end
        if (win_left > 0) begin
          er = ~(ROWS'(1) << cur_r);
          ec = ~(COLORS'(1) << cur_p);
          if (row_en_n == er && col_en_n == ec)
            wcnt++;
          else if (!((&row_en_n) && (&col_en_n)))
            stray++;
          win_left--;
          if (win_left == 0 && q_on.size() > 0) begin
            oe = q_on.pop_front();
            chk("on_pos", cur_r * COLORS + cur_p,
                oe.row * COLORS + oe.plane);
            chk("on_time", wcnt, oe.cnt);
            chk("on_stray", stray, 0);
          end
        end
        prev_sclk = ser_clk;
        prev_lat = ser_latch;
      end
    end
  end

  // Stimulus
  initial begin
    int k;
    for (int b = 0; b < 2; b++)
      for (int c = 0; c < COLORS; c++)
        for (int r = 0; r < ROWS; r++)
          mdl[b][c][r] = '0;
    rst = 1'b1;
    wr_en = 1'b0;
    wr_color = '0;
    wr_row = '0;
    wr_col = '0;
    wr_data = 1'b0;
    swap_req = 1'b0;
    bright = '0;
    repeat (3) @(negedge clk);
    chk("rst_ser_data", int'(ser_data), 0);
    chk("rst_ser_clk", int'(ser_clk), 0);
    chk("rst_ser_latch", int'(ser_latch), 0);
    chk("rst_swap_ack", int'(swap_ack), 0);
    chk("rst_frame_start", int'(frame_start), 0);
    chk("rst_row_en_n", int'(row_en_n), (1 << ROWS) - 1);
    chk("rst_col_en_n", int'(col_en_n), (1 << COLORS) - 1);
    rst = 1'b0;
    after_rst();

    // Give both banks known contents.
    clear_back();
    swap_and_wait();
    clear_back();

    // Single pixel at the first shifted column.
    wr(0, 0, 7, 1'b1);
    swap_and_wait();
    push_words();

    // Back-bank writes without a swap stay invisible.
    wr(1, 2, 3, 1'b1);
    wr(0, 5, 0, 1'b1);
    for (int f = 0; f < 3; f++) begin
      wait_fs();
      push_words();
    end

    // Per-plane duty, then fully dark.
    bright = 4'b1101;
    wait_fs();
    push_on();
    wait_fs();
    bright = 4'b0000;
    push_on();
    wait_fs();
    bright = 4'b1101;

    // Out-of-range write plus a write in the swap clk.
    wait_fs();
    wr_en = 1'b1;
    wr_color = 1'b0;
    wr_row = 3'd6;
    wr_col = 3'd1;
    wr_data = 1'b1;
    swap_req = 1'b1;
    @(negedge clk);
    wr_en = 1'b0;
    swap_req = 1'b0;
    repeat (FR_CLK - 2) @(negedge clk);
    wr_en = 1'b1;
    wr_color = 1'b1;
    wr_row = 3'd3;
    wr_col = 3'd2;
    wr_data = 1'b1;
    mdl[mb ^ 1][1][3][2] = 1'b1;
    @(negedge clk);
    wr_en = 1'b0;
    chk("coll_fs", int'(frame_start), 1);
    chk("coll_ack", int'(swap_ack), 1);
    mb ^= 1;
    exp_acks++;
    push_words();
    wait_fs();
    push_words();

    // Reset in an ON window with a swap pending.
    wait_fs();
    swap_req = 1'b1;
    @(negedge clk);
    swap_req = 1'b0;
    k = 0;
    while ((&row_en_n) && k < 400) begin
      @(negedge clk);
      k++;
    end
    chk("on_seen", int'(&row_en_n), 0);
    #1 rst = 1'b1;
    #1;
    chk("async_row_blank", int'(row_en_n), (1 << ROWS) - 1);
    chk("async_col_blank", int'(col_en_n), (1 << COLORS) - 1);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    mb = 0;
    after_rst();
    push_words();
    push_on();
    wait_fs();

    chk("ack_count", acks, exp_acks);
    chk("words_drained", q_w.size(), 0);
    chk("on_drained", q_on.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==",
             applied, errs);
    $finish;
  end

endmodule

// File: doc/led_matrix_scanner.md
# led_matrix_scanner

Parametrised multiplexed LED-matrix driver for ROWS x COLS panels with COLORS colour planes, fed through a serial-in/latched-out column shift register. It holds a double-buffered 1-bit-per-pixel frame store written through a simple pixel port, and swaps buffers only at frame boundaries. It scans row by row and plane by plane, applying per-plane PWM brightness, and generates its own scan tick from the system clock. It sits between the pattern/graphics logic and the panel pins, and replaces the fixed 8x8 bicolour driver.

## Interface
- ROWS, 8, number of matrix rows (2..32)
- COLS, 8, shift-register bits per row (2..32)
- COLORS, 2, colour planes (1..4)
- BB, 2, brightness bits per plane; on-window is 2**BB ticks
- CLK_DIV, 1350, clk cycles per scan tick (>=2)

Ports:
- clk  in  1  system clock; one clock domain, all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- wr_en  in  1  pixel write strobe, one write per cycle
- wr_color  in  clog2(COLORS) max 1  plane index
- wr_row  in  clog2(ROWS)  row index
- wr_col  in  clog2(COLS)  column index
- wr_data  in  1  pixel value
- swap_req  in  1  request a front/back swap at the next frame boundary
- swap_ack  out  1  one-clk pulse when the swap takes effect
- bright  in  COLORS*BB  per-plane duty; plane c is bits [c*BB +: BB]
- ser_data  out  1  serial column data
- ser_clk  out  1  shift clock; data is stable across its rising edge
- ser_latch  out  1  storage-register latch pulse
- row_en_n  out  ROWS  active-low one-hot row enable
- col_en_n  out  COLORS  active-low plane enable
- frame_start  out  1  one-clk pulse at the start of row 0, plane 0

## Operation
- Tick divider: counter 0..CLK_DIV-1; internal tick fires for one clk when the counter wraps. The scan FSM advances only on ticks.
- Frame store: two banks of COLORS x ROWS x COLS bits, initialised to 0 at configuration and not cleared by rst. Writes always go to the back bank.
- Writes with wr_row >= ROWS, wr_col >= COLS or wr_color >= COLORS are ignored.
- Scan order: row 0 plane 0, row 0 plane 1, ..., row 0 plane COLORS-1, row 1 plane 0, ... Wraps after the last row and last plane.
- States for one (row, plane) slot:
  - SHIFT_LO (ser_clk=0, ser_data = front[plane][row][col], col from COLS-1 down to 0) -> SHIFT_HI (ser_clk=1). The pair repeats COLS times.
  - LATCH: ser_latch=1 for one tick; bright for this plane is captured here.
  - ON: 2**BB ticks. row_en_n[row]=0 and col_en_n[plane]=0 during the first captured-bright ticks. Bright=0 means the row stays dark for the whole window.
  - Next slot begins at SHIFT_LO.
- Outside ON, every enable is 1 (blanked while shifting, no ghosting).
- Swap:
  - swap_req sets a pending flag, which stays set while pending; multiple requests merge into one.
  - At a frame wrap with the flag set, the bank pointer toggles, swap_ack pulses and the flag clears.
  - If swap_req is asserted in the same clk as the swap, the request is consumed by that swap.
- Write/swap collision: a write in the swap clk uses the pre-toggle pointer, so it lands in the bank that becomes front.

## Timing
- Slot length = 2*COLS + 1 + 2**BB ticks.
- Frame length = ROWS*COLORS*slot ticks. Default: 8*2*21 = 336 ticks.
- All outputs are registered and change one clk after the tick.
- frame_start and swap_ack occur in the same clk: the first SHIFT_LO of row 0, plane 0.
- Reset values:
  - ser_data=0, ser_clk=0, ser_latch=0, swap_ack=0, frame_start=0
  - row_en_n all 1, col_en_n all 1
  - divider 0, FSM at row 0 plane 0 SHIFT_LO with column COLS-1, bank pointer 0, pending flag 0
- First tick after reset release emits frame_start.
- rst mid-frame blanks the enables immediately (asynchronously) and discards any pending swap; bank contents are retained.

## Test plan
- Reset, write pixel (color0,row0,col7)=1 to the back bank, pulse swap_req, run one frame -> swap_ack and frame_start coincide once; in the row 0 plane 0 slot, the first ser_data bit sampled on ser_clk rise is 1 and the other 7 are 0.
- Without swap_req, write the back bank -> serialized data stays all zeros for 3 frames.
- bright=2'b01 for plane 0, 2'b11 for plane 1 -> col_en_n[0] low for 1 tick and col_en_n[1] low for 3 ticks of each 4-tick ON window; bright=0 -> never low.
- CLK_DIV=4 -> ser_clk period is 8 clk, ser_latch high for 4 clk, frame_start period is 336*4 clk.
- Write with wr_row=ROWS (out of range) -> no change to any bank; write coincident with the swap clk -> value appears in the new front bank on the next frame.
- Assert rst in the middle of an ON window -> row_en_n/col_en_n go to all 1 without waiting for clk; after release, frame_start pulses on the first tick and the bank pointer is 0.
